// File: rtl/bus_arbiter_2to1.sv
// Two-master / one-slave bus arbiter: one transaction in flight, grant held until slave ready,
// round-robin or fixed priority on contention. Optional slave watchdog under BUS_ARBITER_TIMEOUT_EN.
module bus_arbiter_2to1 #(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int ROUND_ROBIN    = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_m0_request,
  input  logic                     i_m0_rw,
  input  logic [ADDRESS_WIDTH-1:0] i_m0_address,
  input  logic [DATA_WIDTH-1:0]    i_m0_wdata,
  output logic [DATA_WIDTH-1:0]    o_m0_rdata,
  output logic                     o_m0_ready,
  input  logic                     i_m1_request,
  input  logic                     i_m1_rw,
  input  logic [ADDRESS_WIDTH-1:0] i_m1_address,
  input  logic [DATA_WIDTH-1:0]    i_m1_wdata,
  output logic [DATA_WIDTH-1:0]    o_m1_rdata,
  output logic                     o_m1_ready,
  output logic                     o_s_request,
  output logic                     o_s_rw,
  output logic [ADDRESS_WIDTH-1:0] o_s_address,
  output logic [DATA_WIDTH-1:0]    o_s_wdata,
  input  logic [DATA_WIDTH-1:0]    i_s_rdata,
  input  logic                     i_s_ready,
  output logic                     o_fault
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t r_state;
  state_t w_next_state;
  logic   r_grant;
  logic   w_next_grant;
  logic   r_last_grant;
  logic   w_next_last_grant;
  logic   w_pick;
  logic   w_start;
  logic   w_expire;
  logic   w_done;
  logic [DATA_WIDTH-1:0] w_rdata;

  // On contention the port that was not served last wins, unless fixed priority is selected.
  always_comb begin
    if (i_m0_request && i_m1_request) begin
      w_pick = (ROUND_ROBIN != 0) ? ~r_last_grant : 1'b0;
    end else begin
      w_pick = i_m1_request;
    end
  end

  assign w_start = (r_state == ST_IDLE) && (i_m0_request || i_m1_request);

`ifdef BUS_ARBITER_TIMEOUT_EN
  localparam int WDOG_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [WDOG_W-1:0] r_wdog;
  logic              r_fault;

  // A slave ready arriving on the expiry cycle wins: that is a normal completion.
  assign w_expire = (r_state == ST_BUSY) && !i_s_ready &&
                    (r_wdog == WDOG_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_wdog  <= '0;
      r_fault <= 1'b0;
    end else begin
      if (w_start) begin
        r_wdog <= '0;
      end else if ((r_state == ST_BUSY) && !i_s_ready && !w_expire) begin
        r_wdog <= r_wdog + 1'b1;
      end
      if (w_expire) begin
        r_fault <= 1'b1;
      end
    end
  end

  assign o_fault = r_fault;
`else
  logic w_unused_timeout;

  assign w_expire         = 1'b0;
  assign o_fault          = 1'b0;
  assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  assign w_done = (r_state == ST_BUSY) && (i_s_ready || w_expire);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
    w_next_state      = r_state;
    w_next_grant      = r_grant;
    w_next_last_grant = r_last_grant;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_next_state      = ST_BUSY;
          w_next_grant      = w_pick;
          w_next_last_grant = w_pick;
        end
      end
      ST_BUSY: begin
        if (w_done) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state      <= ST_IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state      <= w_next_state;
      r_grant      <= w_next_grant;
      r_last_grant <= w_next_last_grant;
    end
  end

  // Slave command follows the registered grant; the bus is parked at zero while idle.
  always_comb begin
    o_s_request = (r_state == ST_BUSY);
    o_s_rw      = 1'b0;
    o_s_address = '0;
    o_s_wdata   = '0;
    if (r_state == ST_BUSY) begin
      if (r_grant) begin
        o_s_rw      = i_m1_rw;
        o_s_address = i_m1_address;
        o_s_wdata   = i_m1_wdata;
      end else begin
        o_s_rw      = i_m0_rw;
        o_s_address = i_m0_address;
        o_s_wdata   = i_m0_wdata;
      end
    end
  end

  // A watchdog expiry completes the master with zero data.
  assign w_rdata    = i_s_ready ? i_s_rdata : '0;
  assign o_m0_ready = w_done && !r_grant;
  assign o_m1_ready = w_done && r_grant;
  assign o_m0_rdata = o_m0_ready ? w_rdata : '0;
  assign o_m1_rdata = o_m1_ready ? w_rdata : '0;

endmodule

// File: tb/tb_bus_arbiter_2to1.sv
// Scoreboard bench for bus_arbiter_2to1: random masters and slave, arbitration reference model,
// directed reset-abort, stall/timeout and fixed-priority scenarios.
`timescale 1ns/1ps
module tb_bus_arbiter_2to1;
  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct packed {
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } txn_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst_n;
  logic [1:0]            m_req;
  logic [1:0]            m_rw;
  logic [1:0][AW-1:0]    m_addr;
  logic [1:0][DW-1:0]    m_wdata;
  logic [1:0][DW-1:0]    m_rdata;
  logic [1:0]            m_ready;
  logic                  s_req;
  logic                  s_rw;
  logic [AW-1:0]         s_addr;
  logic [DW-1:0]         s_wdata;
  logic [DW-1:0]         s_rdata;
  logic                  s_ready;
  logic                  fault;

  logic [1:0]            f_req;
  logic [1:0]            f_ready;
  logic [DW-1:0]         f_rdata0, f_rdata1, f_s_wdata;
  logic [AW-1:0]         f_s_addr;
  logic                  f_s_req, f_s_rw, f_fault;

  bus_arbiter_2to1 #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .ROUND_ROBIN(1)) u_dut (
    .i_clock(clk), .i_reset(rst_n),
    .i_m0_request(m_req[0]), .i_m0_rw(m_rw[0]), .i_m0_address(m_addr[0]), .i_m0_wdata(m_wdata[0]),
    .o_m0_rdata(m_rdata[0]), .o_m0_ready(m_ready[0]),
    .i_m1_request(m_req[1]), .i_m1_rw(m_rw[1]), .i_m1_address(m_addr[1]), .i_m1_wdata(m_wdata[1]),
    .o_m1_rdata(m_rdata[1]), .o_m1_ready(m_ready[1]),
    .o_s_request(s_req), .o_s_rw(s_rw), .o_s_address(s_addr), .o_s_wdata(s_wdata),
    .i_s_rdata(s_rdata), .i_s_ready(s_ready), .o_fault(fault)
  );

  // Fixed-priority instance with a slave that answers in the first busy cycle.
  bus_arbiter_2to1 #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .ROUND_ROBIN(0)) u_fix (
    .i_clock(clk), .i_reset(rst_n),
    .i_m0_request(f_req[0]), .i_m0_rw(1'b0), .i_m0_address(32'h0000_0010), .i_m0_wdata(32'h0),
    .o_m0_rdata(f_rdata0), .o_m0_ready(f_ready[0]),
    .i_m1_request(f_req[1]), .i_m1_rw(1'b1), .i_m1_address(32'h0000_0020), .i_m1_wdata(32'h1),
    .o_m1_rdata(f_rdata1), .o_m1_ready(f_ready[1]),
    .o_s_request(f_s_req), .o_s_rw(f_s_rw), .o_s_address(f_s_addr), .o_s_wdata(f_s_wdata),
    .i_s_rdata(32'h0), .i_s_ready(f_s_req), .o_fault(f_fault)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] slave_data(input logic [AW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
  endfunction

  // Slave model: answers after a random wait, returning data derived from the address.
  bit          s_hold    = 1'b0;
  int unsigned s_maxwait = 3;
  int unsigned s_wait    = 0;
  initial begin
    s_ready = 1'b0;
    s_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      s_ready = 1'b0;
      s_rdata = $urandom;
      if (s_req && !s_hold) begin
        if (s_wait == 0) begin
          s_ready = 1'b1;
          s_rdata = slave_data(s_addr);
          s_wait  = $urandom_range(s_maxwait, 0);
        end else begin
          s_wait--;
        end
      end
    end
  end

  // Scoreboard queues and arbitration reference model.
  txn_t q0[$];
  txn_t q1[$];
  int   gq[$];
  int   grant_log[$];
  bit   mon_en      = 1'b0;
  int   last_served = 1;
  bit   prev_start  = 1'b0;
  bit   prev_done   = 1'b0;
  int   mon_g, mon_p;
  bit   mon_have;
  txn_t mon_e;

  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_start) check("latency_s_request", {31'd0, s_req}, 32'd1);
      if (prev_done)  check("turnaround_s_request", {31'd0, s_req}, 32'd0);
      prev_start = 1'b0;
      prev_done  = 1'b0;
      if (!s_req) begin
        if (m_req != 2'b00) begin
          if (m_req == 2'b11) mon_g = 1 - last_served;
          else                mon_g = m_req[1] ? 1 : 0;
          gq.push_back(mon_g);
          last_served = mon_g;
          prev_start  = 1'b1;
        end
        check("idle_s_address", s_addr, 32'd0);
        check("idle_s_wdata", s_wdata, 32'd0);
        check("idle_s_rw", {31'd0, s_rw}, 32'd0);
        check("idle_m_ready", {30'd0, m_ready}, 32'd0);
      end
      if (m_ready != 2'b00) begin
        prev_done = 1'b1;
        mon_p = m_ready[1] ? 1 : 0;
        check("ready_exclusive", {30'd0, m_ready}, (mon_p == 1) ? 32'd2 : 32'd1);
        check("ungranted_rdata", m_rdata[1-mon_p], 32'd0);
        grant_log.push_back(mon_p);
        if (gq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL grant_port: ready on port %0d with no grant expected", mon_p);
        end else begin
          check("grant_port", mon_p, gq.pop_front());
        end
        mon_have = 1'b0;
        if (mon_p == 0 && q0.size() > 0) begin mon_e = q0.pop_front(); mon_have = 1'b1; end
        if (mon_p == 1 && q1.size() > 0) begin mon_e = q1.pop_front(); mon_have = 1'b1; end
        if (!mon_have) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_ready: port %0d ready with no outstanding transaction", mon_p);
        end else begin
          check("m_rdata", m_rdata[mon_p], mon_e.rdata);
          check("s_address", s_addr, mon_e.addr);
          check("s_rw", {31'd0, s_rw}, {31'd0, mon_e.rw});
          if (mon_e.rw) check("s_wdata", s_wdata, mon_e.wdata);
        end
      end
    end
  end

  // Issue one transaction on port p (called at posedge+1) and wait for its ready.
  task automatic do_txn(input int p, input logic rw, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rdata, input int budget);
    txn_t e;
    bit   ok;
    e.rw = rw; e.addr = addr; e.wdata = wdata; e.rdata = exp_rdata;
    if (p == 0) q0.push_back(e); else q1.push_back(e);
    m_req[p] = 1'b1; m_rw[p] = rw; m_addr[p] = addr; m_wdata[p] = wdata;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (m_ready[p]) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL ready_timeout_port%0d: ready=0 after %0d cycles, required 1", p, budget);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_master(input int p, input int n, input int maxgap);
    logic [AW-1:0] a;
    int gap;
    for (int i = 0; i < n; i++) begin
      a = $urandom;
      do_txn(p, 1'($urandom_range(1, 0)), a, $urandom, slave_data(a), 60);
      gap = $urandom_range(maxgap, 0);
      if (gap > 0) begin
        m_req[p] = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
      end
    end
    m_req[p] = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int base, cnt;
    bit seen;
    logic [AW-1:0] a;
    txn_t e;

    rst_n = 1'b0; m_req = '0; m_rw = '0; m_addr = '0; m_wdata = '0; f_req = '0;
    repeat (3) @(negedge clk);
    check("reset_s_request", {31'd0, s_req}, 32'd0);
    check("reset_m_ready", {30'd0, m_ready}, 32'd0);
    check("reset_fault", {31'd0, fault}, 32'd0);
    check("reset_s_address", s_addr, 32'd0);
    check("reset_m0_rdata", m_rdata[0], 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    // Single read on port 0, then single write on port 1.
    do_txn(0, 1'b0, 32'h0000_0100, 32'h0, slave_data(32'h0000_0100), 50);
    m_req[0] = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    do_txn(1, 1'b1, 32'h0000_2004, 32'hDEAD_BEEF, slave_data(32'h0000_2004), 50);
    m_req[1] = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    // Continuous contention: strict alternation starting with port 0.
    base = grant_log.size();
    fork
      run_master(0, 4, 0);
      run_master(1, 4, 0);
    join
    check("rr_grant_count", grant_log.size() - base, 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (base + i < grant_log.size()) check("rr_order", grant_log[base+i], i % 2);
    end
    repeat (2) begin @(posedge clk); #1; end

    // Fixed priority: port 0 always wins while both request.
    f_req = 2'b11;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (f_ready != 2'b00) begin
        cnt++;
        check("fixed_prio_grant", {30'd0, f_ready}, 32'd1);
      end
    end
    check("fixed_prio_count", cnt, 32'd6);
    @(posedge clk); #1;
    f_req = 2'b10;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (f_ready[1]) seen = 1'b1;
    end
    check("fixed_prio_m1_alone", {31'd0, seen}, 32'd1);
    @(posedge clk); #1;
    f_req = 2'b00;

    // Reset in the middle of a transaction aborts it without a ready pulse.
    s_hold = 1'b1;
    m_req[0] = 1'b1; m_rw[0] = 1'b0; m_addr[0] = 32'h0000_0ABC;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (s_req) begin seen = 1'b1; break; end
    end
    check("abort_reached_busy", {31'd0, seen}, 32'd1);
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("abort_s_request_async", {31'd0, s_req}, 32'd0);
    check("abort_m_ready", {30'd0, m_ready}, 32'd0);
    m_req = '0;
    q0.delete(); q1.delete(); gq.delete();
    prev_start = 1'b0; prev_done = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("abort_no_ready", {30'd0, m_ready}, 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    last_served = 1;
    s_hold = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;
    do_txn(1, 1'b0, 32'h0000_3000, 32'h0, slave_data(32'h0000_3000), 50);
    m_req[1] = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    // Randomized traffic on both ports.
    fork
      run_master(0, 30, 3);
      run_master(1, 30, 3);
    join
    repeat (3) begin @(posedge clk); #1; end

    // Stalled slave: the arbiter keeps waiting (watchdog build: expires after TIMEOUT_CYCLES).
    s_hold = 1'b1;
    a = 32'h0000_4444;
    e.rw = 1'b0; e.addr = a; e.wdata = '0;
`ifdef BUS_ARBITER_TIMEOUT_EN
    e.rdata = '0;
`else
    e.rdata = slave_data(a);
`endif
    q0.push_back(e);
    m_req[0] = 1'b1; m_rw[0] = 1'b0; m_addr[0] = a;
    seen = 1'b0;
    cnt = 0;
    for (int i = 0; i < 101; i++) begin
      @(negedge clk);
      if (s_req) cnt++;
      if (m_ready[0]) seen = 1'b1;
    end
    check("stall_no_ready", {31'd0, seen}, 32'd0);
    check("stall_still_busy", {31'd0, s_req}, 32'd1);
    check("stall_fault_low", {31'd0, fault}, 32'd0);
`ifdef BUS_ARBITER_TIMEOUT_EN
    for (int i = 0; i < 1100 && !seen; i++) begin
      @(negedge clk);
      if (s_req) cnt++;
      if (m_ready[0]) seen = 1'b1;
    end
    check("timeout_ready", {31'd0, seen}, 32'd1);
    check("timeout_busy_cycles", cnt, 32'd1024);
    @(posedge clk); #1;
    m_req[0] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("timeout_fault_sticky", {31'd0, fault}, 32'd1);
    end
`else
    s_hold = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (m_ready[0]) seen = 1'b1;
    end
    check("stall_release_ready", {31'd0, seen}, 32'd1);
    @(posedge clk); #1;
    m_req[0] = 1'b0;
    repeat (2) @(negedge clk);
    check("no_watchdog_fault", {31'd0, fault}, 32'd0);
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_drained", q0.size() + q1.size() + gq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
